// File: rtl/tt_freq_pkg.sv
// Shared types and default constants for the frequency meter.
package tt_freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ         = 60000000;
    localparam int unsigned GATE_CYCLES_1S = 60000000;
    localparam int unsigned CNT_W          = 26;

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge pulse.
module tt_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise
);

    // sh[1:0] is the synchronizer; sh[2] holds the previous synchronized level
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], pin};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/tt_freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clk cycles.
module tt_freq_meter
    import tt_freq_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = tt_freq_pkg::GATE_CYCLES_1S,
    parameter int unsigned CNT_W       = tt_freq_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sig_in,
    input  logic [1:0]       byte_sel,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             meas_valid,
    output logic             ovf,
    output logic             busy,
    output logic [7:0]       byte_out
);

    // Gate counter is sized from the window length, independent of CNT_W
    localparam int unsigned     GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [GATE_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic               sat;
    logic               rise;
    logic               last_gate;
    logic [29:0]        cnt_ext;

    tt_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sig_in),
        .rise  (rise)
    );

    assign last_gate = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ena) next_state = GATE;
            GATE: begin
                if (!ena)           next_state = IDLE;
                else if (last_gate) next_state = DONE;
            end
            DONE:    next_state = ena ? GATE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) begin
                if (edge_cnt == '1) sat <= 1'b1;
                else                edge_cnt <= edge_cnt + 1'b1;
            end
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end
    end

    // Result and its valid pulse are registered together, so freq_cnt is
    // already updated in the cycle meas_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_cnt   <= '0;
            ovf        <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= (state == DONE);
            if (state == DONE) begin
                freq_cnt <= edge_cnt;
                ovf      <= sat;
            end
        end
    end

    assign busy    = (state == GATE);
    assign cnt_ext = 30'(freq_cnt);

    always_comb begin
        byte_out = '0;
        case (byte_sel)
            2'd0:    byte_out = cnt_ext[7:0];
            2'd1:    byte_out = cnt_ext[15:8];
            2'd2:    byte_out = cnt_ext[23:16];
            default: byte_out = {ovf, busy, cnt_ext[29:24]};
        endcase
    end

endmodule

// File: tb/tb_tt_freq_meter.sv
// Scoreboard bench: three meter instances with different windows/widths.
module tb_tt_freq_meter;

    typedef struct packed {
        logic [25:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_bc = 1'b0;
    logic        ena_a = 1'b0, ena_b = 1'b0, ena_c = 1'b0;
    logic [2:0]  sig = '0;
    logic [1:0]  byte_sel = 2'd0;

    logic [25:0] cnt_a, cnt_c;
    logic [3:0]  cnt_b;
    logic        mv_a, mv_b, mv_c, ovf_a, ovf_b, ovf_c, busy_a, busy_b, busy_c;
    logic [7:0]  byte_a, byte_b, byte_c;

    int unsigned per [3] = '{0, 0, 0};
    logic        lvl [3] = '{1'b0, 1'b0, 1'b0};
    int unsigned ph  [3] = '{0, 0, 0};

    exp_t        q_a[$], q_b[$], q_c[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_freq_meter #(.GATE_CYCLES(1000), .CNT_W(26)) u_a (
        .clk(clk), .rst_n(rst_a), .ena(ena_a), .sig_in(sig[0]), .byte_sel(byte_sel),
        .freq_cnt(cnt_a), .meas_valid(mv_a), .ovf(ovf_a), .busy(busy_a), .byte_out(byte_a));

    tt_freq_meter #(.GATE_CYCLES(200), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_bc), .ena(ena_b), .sig_in(sig[1]), .byte_sel(byte_sel),
        .freq_cnt(cnt_b), .meas_valid(mv_b), .ovf(ovf_b), .busy(busy_b), .byte_out(byte_b));

    tt_freq_meter #(.GATE_CYCLES(3000), .CNT_W(26)) u_c (
        .clk(clk), .rst_n(rst_bc), .ena(ena_c), .sig_in(sig[2]), .byte_sel(byte_sel),
        .freq_cnt(cnt_c), .meas_valid(mv_c), .ovf(ovf_c), .busy(busy_c), .byte_out(byte_c));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_mv(input int unsigned which, input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = mv_a;
                1:       seen = mv_b;
                default: seen = mv_c;
            endcase
        end
    endtask

    // Square-wave / level generators; a period of 0 holds lvl[i]
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (per[i] == 0) begin
                sig[i] = lvl[i];
                ph[i]  = 0;
            end else begin
                sig[i] = (ph[i] < (per[i] + 1) / 2);
                ph[i]  = (ph[i] + 1) % per[i];
            end
        end
    end

    // Monitors: every meas_valid must match the oldest expected result
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mv_a === 1'b1) begin
            if (q_a.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                chk("a_freq_cnt", 32'(cnt_a), 32'(e.cnt));
                chk("a_ovf", 32'(ovf_a), 32'(e.ovf));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mv_b === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                chk("b_freq_cnt", 32'(cnt_b), 32'(e.cnt));
                chk("b_ovf", 32'(ovf_b), 32'(e.ovf));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mv_c === 1'b1) begin
            if (q_c.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q_c.pop_front();
                chk("c_freq_cnt", 32'(cnt_c), 32'(e.cnt));
                chk("c_ovf", 32'(ovf_c), 32'(e.ovf));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int unsigned t1, t2;

        repeat (3) @(negedge clk);
        chk("rst_a_freq_cnt", 32'(cnt_a), 32'd0);
        chk("rst_a_meas_valid", 32'(mv_a), 32'd0);
        chk("rst_a_ovf", 32'(ovf_a), 32'd0);
        chk("rst_a_busy", 32'(busy_a), 32'd0);
        rst_a  = 1'b1;
        rst_bc = 1'b1;

        fork
            begin : seq_a
                // 1000-cycle window, one edge per 10 cycles -> exactly 100
                per[0] = 10;
                repeat (20) @(negedge clk);
                q_a.push_back(exp_t'{cnt: 26'd100, ovf: 1'b0});
                q_a.push_back(exp_t'{cnt: 26'd100, ovf: 1'b0});
                ena_a = 1'b1;
                wait_mv(0, 5000, seen);
                chk("a_valid1_seen", 32'(seen), 32'd1);
                t1 = cyc;
                wait_mv(0, 5000, seen);
                chk("a_valid2_seen", 32'(seen), 32'd1);
                t2 = cyc;
                ena_a = 1'b0;
                chk("a_b2b_spacing", t2 - t1, 32'd1001);
                repeat (5) @(negedge clk);
                chk("a_idle_busy", 32'(busy_a), 32'd0);

                // abort mid-window: no result, previous value held
                ena_a = 1'b1;
                @(posedge clk);
                repeat (500) @(negedge clk);
                chk("a_busy_in_gate", 32'(busy_a), 32'd1);
                ena_a = 1'b0;
                @(posedge clk);
                #1;
                chk("a_abort_busy", 32'(busy_a), 32'd0);
                chk("a_abort_hold", 32'(cnt_a), 32'd100);
                repeat (1100) @(negedge clk);
                chk("a_abort_hold_late", 32'(cnt_a), 32'd100);
                q_a.push_back(exp_t'{cnt: 26'd100, ovf: 1'b0});
                ena_a = 1'b1;
                wait_mv(0, 5000, seen);
                chk("a_reenable_seen", 32'(seen), 32'd1);
                ena_a = 1'b0;

                // asynchronous reset mid-window
                repeat (10) @(negedge clk);
                ena_a = 1'b1;
                repeat (300) @(negedge clk);
                #2 rst_a = 1'b0;
                #1;
                chk("a_midrst_freq_cnt", 32'(cnt_a), 32'd0);
                chk("a_midrst_busy", 32'(busy_a), 32'd0);
                chk("a_midrst_valid", 32'(mv_a), 32'd0);
                chk("a_midrst_ovf", 32'(ovf_a), 32'd0);
                ena_a = 1'b0;
                @(negedge clk);
                rst_a = 1'b1;
                repeat (20) @(negedge clk);
                q_a.push_back(exp_t'{cnt: 26'd100, ovf: 1'b0});
                ena_a = 1'b1;
                wait_mv(0, 5000, seen);
                chk("a_restart_seen", 32'(seen), 32'd1);
                ena_a = 1'b0;

                // static levels: no edges inside the window
                per[0] = 0;
                lvl[0] = 1'b0;
                repeat (10) @(negedge clk);
                q_a.push_back(exp_t'{cnt: 26'd0, ovf: 1'b0});
                ena_a = 1'b1;
                wait_mv(0, 5000, seen);
                chk("a_low_seen", 32'(seen), 32'd1);
                ena_a = 1'b0;
                lvl[0] = 1'b1;
                repeat (10) @(negedge clk);
                q_a.push_back(exp_t'{cnt: 26'd0, ovf: 1'b0});
                ena_a = 1'b1;
                wait_mv(0, 5000, seen);
                chk("a_high_seen", 32'(seen), 32'd1);
                ena_a = 1'b0;
            end
            begin : seq_bc
                // 4-bit counter, 50 edges in 200 cycles -> saturates
                per[1] = 4;
                repeat (20) @(negedge clk);
                q_b.push_back(exp_t'{cnt: 26'd15, ovf: 1'b1});
                ena_b = 1'b1;
                wait_mv(1, 1000, seen);
                chk("b_sat_seen", 32'(seen), 32'd1);
                ena_b = 1'b0;
                per[1] = 0;
                lvl[1] = 1'b0;
                repeat (5) @(negedge clk);
                byte_sel = 2'd3; #1 chk("b_byte3_ovf", 32'(byte_b), 32'h80);
                byte_sel = 2'd0; #1 chk("b_byte0", 32'(byte_b), 32'h0F);
                byte_sel = 2'd1; #1 chk("b_byte1", 32'(byte_b), 32'h00);
                q_b.push_back(exp_t'{cnt: 26'd0, ovf: 1'b0});
                ena_b = 1'b1;
                wait_mv(1, 1000, seen);
                chk("b_idle_seen", 32'(seen), 32'd1);
                ena_b = 1'b0;
                repeat (3) @(negedge clk);
                byte_sel = 2'd3; #1 chk("b_byte3_clear", 32'(byte_b), 32'h00);

                // 3000-cycle window, one edge per 3 cycles -> exactly 1000
                per[2] = 3;
                repeat (20) @(negedge clk);
                q_c.push_back(exp_t'{cnt: 26'd1000, ovf: 1'b0});
                ena_c = 1'b1;
                repeat (10) @(negedge clk);
                byte_sel = 2'd3; #1 chk("c_byte3_busy", 32'(byte_c), 32'h40);
                wait_mv(2, 5000, seen);
                chk("c_seen", 32'(seen), 32'd1);
                ena_c = 1'b0;
                repeat (3) @(negedge clk);
                byte_sel = 2'd0; #1 chk("c_byte0", 32'(byte_c), 32'hE8);
                byte_sel = 2'd1; #1 chk("c_byte1", 32'(byte_c), 32'h03);
                byte_sel = 2'd2; #1 chk("c_byte2", 32'(byte_c), 32'h00);
                byte_sel = 2'd3; #1 chk("c_byte3", 32'(byte_c), 32'h00);
            end
        join

        repeat (20) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);
        chk("c_queue_drained", q_c.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
